// File: rtl/pa_spsram_param_pkg.sv
// Shared definitions for the parametrised single-port SRAM: clear-FSM encoding
// and write-slice width helpers.
package pa_spsram_param_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int slice_width(input int data_width, input int we_width);
    return (we_width > 0) ? (data_width / we_width) : data_width;
  endfunction

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_WE_WIDTH   = 32;
  localparam int DEF_SLICE_W    = slice_width(DEF_DATA_WIDTH, DEF_WE_WIDTH);

endpackage

// File: rtl/pa_spsram_param_if.sv
// Request/response bundle of the SRAM. Handshake: a request is taken on every
// rising edge with CEN=0 while INIT_BUSY=0; QVLD marks the cycle Q carries new read data.
interface pa_spsram_param_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int WE_WIDTH   = 32
);
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [WE_WIDTH-1:0]   WEN;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;
  logic                  QVLD;
  logic                  INIT_BUSY;

  modport master (output A, CEN, GWEN, WEN, D, input Q, QVLD, INIT_BUSY);
  modport slave  (input A, CEN, GWEN, WEN, D, output Q, QVLD, INIT_BUSY);
endinterface

// File: rtl/pa_spsram_param_array.sv
// Pure synchronous single-port array; swap this file for a foundry macro.
// Q only changes on a read edge; the storage is never reset.
module pa_spsram_param_array
  import pa_spsram_param_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int WE_WIDTH   = 32
) (
  input  logic                  CLK,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q
);

  localparam int SLICE_W = slice_width(DATA_WIDTH, WE_WIDTH);
  localparam int DEPTH   = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (GWEN) begin
        Q <= mem_q[A];
      end else begin
        for (int s = 0; s < WE_WIDTH; s++) begin
          if (!WEN[s]) mem_q[A][s*SLICE_W +: SLICE_W] <= D[s*SLICE_W +: SLICE_W];
        end
      end
    end
  end

endmodule

// File: rtl/pa_spsram_param.sv
// Parametrised single-port SRAM with post-reset clear sequencer, optional
// output register and read-data-valid strobe.
module pa_spsram_param
  import pa_spsram_param_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    WE_WIDTH   = 32,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter bit                    OUT_REG    = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  pa_spsram_param_if.slave sram_if,
  output state_t           state_o
);

  if ((DATA_WIDTH % WE_WIDTH) != 0) begin : g_bad_cfg
    $error("pa_spsram_param: WE_WIDTH must divide DATA_WIDTH");
  end

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rd_vld_q, rd_vld_d;

  logic                  init_busy;
  logic [ADDR_WIDTH-1:0] arr_a;
  logic                  arr_cen;
  logic                  arr_gwen;
  logic [WE_WIDTH-1:0]   arr_wen;
  logic [DATA_WIDTH-1:0] arr_d;
  logic [DATA_WIDTH-1:0] arr_q;
  logic [DATA_WIDTH-1:0] q_out;
  logic                  qvld_out;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= INIT_EN ? ST_INIT : ST_RUN;
      cnt_q    <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // The last clear write and the move to RUN share one edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // While clearing, the sequencer owns the array and user requests are dropped.
  always_comb begin
    init_busy = (state_q == ST_INIT);
    if (init_busy) begin
      arr_a    = cnt_q;
      arr_cen  = 1'b0;
      arr_gwen = 1'b0;
      arr_wen  = '0;
      arr_d    = INIT_VALUE;
    end else begin
      arr_a    = sram_if.A;
      arr_cen  = sram_if.CEN;
      arr_gwen = sram_if.GWEN;
      arr_wen  = sram_if.WEN;
      arr_d    = sram_if.D;
    end
    rd_vld_d = !init_busy && !sram_if.CEN && sram_if.GWEN;
  end

  pa_spsram_param_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .WE_WIDTH   (WE_WIDTH)
  ) u_array (
    .CLK  (CLK),
    .A    (arr_a),
    .CEN  (arr_cen),
    .GWEN (arr_gwen),
    .WEN  (arr_wen),
    .D    (arr_d),
    .Q    (arr_q)
  );

  if (OUT_REG) begin : g_oreg
    logic [DATA_WIDTH-1:0] q_q;
    logic                  qvld_q;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        q_q    <= '0;
        qvld_q <= 1'b0;
      end else begin
        qvld_q <= rd_vld_q;
        if (rd_vld_q) q_q <= arr_q;
      end
    end
    assign q_out    = q_q;
    assign qvld_out = qvld_q;
  end else begin : g_direct
    // Shadow copy gives Q a reset value without resetting the array itself.
    logic [DATA_WIDTH-1:0] q_hold_q;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) q_hold_q <= '0;
      else if (rd_vld_q) q_hold_q <= arr_q;
    end
    assign q_out    = rd_vld_q ? arr_q : q_hold_q;
    assign qvld_out = rd_vld_q;
  end

  assign sram_if.Q         = q_out;
  assign sram_if.QVLD      = qvld_out;
  assign sram_if.INIT_BUSY = init_busy;
  assign state_o           = state_q;

endmodule

// File: tb/tb_pa_spsram_param.sv
// Bench for pa_spsram_param: two configurations checked cycle by cycle against
// a word-array reference model with a latency queue.
module tb_pa_spsram_param;
  import pa_spsram_param_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst0, rst1;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- shared stimulus, muxed to one DUT ----------------
  bit          sel;
  logic [7:0]  a_v;
  logic        cen_v, gwen_v;
  logic [31:0] wen_v, d_v;
  state_t      st0, st1;

  pa_spsram_param_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WE_WIDTH(32)) if0 ();
  pa_spsram_param_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WE_WIDTH(4))  if1 ();

  assign if0.A    = a_v;
  assign if0.CEN  = sel ? 1'b1 : cen_v;
  assign if0.GWEN = gwen_v;
  assign if0.WEN  = wen_v;
  assign if0.D    = d_v;
  assign if1.A    = a_v[3:0];
  assign if1.CEN  = sel ? cen_v : 1'b1;
  assign if1.GWEN = gwen_v;
  assign if1.WEN  = wen_v[3:0];
  assign if1.D    = d_v;

  pa_spsram_param #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .WE_WIDTH(32),
    .INIT_EN(1'b1), .INIT_VALUE(32'h0), .OUT_REG(1'b0)
  ) u_dut0 (.CLK(clk), .RST(rst0), .sram_if(if0), .state_o(st0));

  pa_spsram_param #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .WE_WIDTH(4),
    .INIT_EN(1'b0), .INIT_VALUE(32'h0), .OUT_REG(1'b1)
  ) u_dut1 (.CLK(clk), .RST(rst1), .sram_if(if1), .state_o(st1));

  logic [31:0] q_obs;
  logic        qvld_obs, busy_obs;
  state_t      st_obs;
  assign q_obs    = sel ? if1.Q : if0.Q;
  assign qvld_obs = sel ? if1.QVLD : if0.QVLD;
  assign busy_obs = sel ? if1.INIT_BUSY : if0.INIT_BUSY;
  assign st_obs   = sel ? st1 : st0;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: word array, per-cycle valid queue, read-data queue.
  logic [31:0] mem_m [256];
  bit          vld_pipe [$];
  logic [31:0] exp_q [$];
  logic [31:0] last_q;
  int          busy_left;
  bit          rst_m;
  int          cur_lat, cur_depth, cur_we;
  bit          cur_init_en;

  task automatic flush_model();
    vld_pipe.delete();
    exp_q.delete();
    for (int i = 0; i < cur_lat; i++) vld_pipe.push_back(1'b0);
    last_q = '0;
  endtask

  task automatic init_model(input int lat, input bit init_en, input int aw, input int we,
                            input logic [31:0] init_val);
    cur_lat     = lat;
    cur_init_en = init_en;
    cur_depth   = 1 << aw;
    cur_we      = we;
    for (int i = 0; i < 256; i++) mem_m[i] = init_val;
    rst_m     = 1'b1;
    busy_left = init_en ? cur_depth : 0;
    flush_model();
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit r, input logic [7:0] a, input logic cen, input logic gwen,
                       input logic [31:0] wen, input logic [31:0] d);
    bit          exp_v;
    bit          exp_busy;
    int          am;
    int          sw;
    @(negedge clk);
    exp_v = vld_pipe.pop_front();
    if (exp_v) last_q = exp_q.pop_front();
    exp_busy = rst_m ? cur_init_en : (busy_left != 0);
    check("qvld", 32'(qvld_obs), 32'(exp_v));
    check("q", q_obs, last_q);
    check("init_busy", 32'(busy_obs), 32'(exp_busy));
    check("state_init", 32'(st_obs == ST_INIT), 32'(exp_busy));

    if (sel) rst1 = r; else rst0 = r;
    a_v = a; cen_v = cen; gwen_v = gwen; wen_v = wen; d_v = d;

    am = int'(a) & (cur_depth - 1);
    sw = 32 / cur_we;
    rst_m = r;
    if (r) begin
      flush_model();
      busy_left = cur_init_en ? cur_depth : 0;
    end else if (busy_left != 0) begin
      vld_pipe.push_back(1'b0);
      busy_left--;
    end else if (!cen && gwen) begin
      vld_pipe.push_back(1'b1);
      exp_q.push_back(mem_m[am]);
    end else begin
      if (!cen) begin
        for (int b = 0; b < 32; b++) if (!wen[b / sw]) mem_m[am][b] = d[b];
      end
      vld_pipe.push_back(1'b0);
    end
  endtask

  task automatic idle();
    cycle(1'b0, 8'h0, 1'b1, 1'b1, '1, '0);
  endtask

  task automatic hold_rst();
    cycle(1'b1, 8'h0, 1'b1, 1'b1, '1, '0);
  endtask

  task automatic rd(input logic [7:0] a);
    cycle(1'b0, a, 1'b0, 1'b1, '1, '0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [31:0] wen);
    cycle(1'b0, a, 1'b0, 1'b0, wen, d);
  endtask

  task automatic rand_cycle(input int amax);
    logic [31:0] wen;
    case ($urandom_range(0, 2))
      0:       wen = '0;
      1:       wen = '1;
      default: wen = $urandom;
    endcase
    cycle(1'b0, 8'($urandom_range(0, amax)), ($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 1)), wen, $urandom);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    sel = 1'b0;
    a_v = '0; cen_v = 1'b1; gwen_v = 1'b1; wen_v = '1; d_v = '0;
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    rst0 = 1'b1; rst1 = 1'b1;

    // Configuration 0: 256x32, bit-wise mask, clear after reset, latency 1.
    init_model(1, 1'b1, 8, 32, 32'h0);
    repeat (2) hold_rst();
    repeat (100) rand_cycle(255);
    repeat (2) hold_rst();
    repeat (256) rand_cycle(255);
    rd(8'd0); rd(8'd128); rd(8'd255); idle();
    wr(8'h10, 32'hDEADBEEF, 32'h0000_0000);
    rd(8'h10);
    wr(8'h10, 32'h12345678, 32'hFFFF_0000);
    rd(8'h10);
    idle();
    repeat (300) rand_cycle(15);
    repeat (200) rand_cycle(255);
    repeat (3) idle();

    // Configuration 1: 16x32, byte mask, no clear, output register.
    sel = 1'b1;
    init_model(2, 1'b0, 4, 4, 32'h0);
    repeat (2) hold_rst();
    wr(8'd3, 32'h5A5A0F0F, 32'h0);
    rd(8'd3);
    for (int i = 0; i < 16; i++) wr(8'(i), $urandom, 32'h0);
    wr(8'd1, 32'hA, 32'h0); wr(8'd2, 32'hB, 32'h0); wr(8'd3, 32'hC, 32'h0);
    rd(8'd1); rd(8'd2); rd(8'd3);
    repeat (4) idle();
    wr(8'd5, 32'hAABBCCDD, 32'h0);
    wr(8'd5, 32'h11223344, 32'hA);
    rd(8'd5);
    repeat (3) idle();
    rd(8'd7);
    repeat (2) hold_rst();
    repeat (2) idle();
    repeat (400) rand_cycle(15);
    repeat (4) idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
